// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - synchroniser, debouncer and press/jump-request logic for board inputs
//
// Conditions the raw slide switches and push-buttons before they reach the game
// logic. Every input is polarity-normalised, double-flop synchronised, debounced,
// and then turned into levels, single-cycle press pulses and a sticky jump request.
//
// Build option: INPUT_DEBOUNCE_EN
//   defined   - per-input stability counters; a level changes only after
//               DEBOUNCE_CYCLES consecutive cycles of a new value
//   undefined - counters removed; the debounced level follows the synchroniser
//
// Ports:
//   vga_clock    in   pixel clock, the only clock
//   reset        in   synchronous active-high reset
//   left_switch  in   raw pin, active-high
//   right_switch in   raw pin, active-high
//   jump_button  in   raw pin, polarity per BUTTON_ACTIVE_LOW
//   start_button in   raw pin, polarity per BUTTON_ACTIVE_LOW
//   jump_ack     in   game logic consumed the jump request
//   move_dir     out  2'b00 idle, 2'b01 right, 2'b10 left (both on gives idle)
//   jump_level   out  debounced jump level
//   jump_press   out  one-cycle pulse on debounced jump rising edge
//   jump_req     out  sticky jump request, cleared by jump_ack
//   start_press  out  one-cycle pulse on debounced start rising edge

module input_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter bit BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic       vga_clock,
  input  logic       reset,
  input  logic       left_switch,
  input  logic       right_switch,
  input  logic       jump_button,
  input  logic       start_button,
  input  logic       jump_ack,
  output logic [1:0] move_dir,
  output logic       jump_level,
  output logic       jump_press,
  output logic       jump_req,
  output logic       start_press
);

  // Bit positions of each input in the per-input vectors.
  localparam int IdxLeft  = 0;
  localparam int IdxRight = 1;
  localparam int IdxJump  = 2;
  localparam int IdxStart = 3;

  logic [3:0] pin_act;
  logic [3:0] s1_q;
  logic [3:0] s2_q;
  logic [3:0] db_q;
  logic [3:0] db_d;
  logic [1:0] press_q;       // [0] jump, [1] start
  logic [1:0] press_d;
  logic       jump_req_q;
  logic       jump_req_d;
  logic [1:0] move_dir_q;
  logic [1:0] move_dir_d;

  // Normalise to active-high before synchronising so every flop after this
  // point resets to the released level (0).
  assign pin_act = {start_button ^ BUTTON_ACTIVE_LOW,
                    jump_button  ^ BUTTON_ACTIVE_LOW,
                    right_switch,
                    left_switch};

`ifdef INPUT_DEBOUNCE_EN
  localparam int CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q [4];
  logic [CntW-1:0] cnt_d [4];

  // Any cycle where s2 agrees with db restarts the count, so a glitch shorter
  // than DEBOUNCE_CYCLES never reaches db.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        db_d[i]  = s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clock) begin
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        cnt_q[i] <= '0;
      end else begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  // Without counters the debounced level is just the synchroniser output,
  // delayed one more flop; the cycle count parameter has no effect.
  if (DEBOUNCE_CYCLES < 1) begin : g_debounce_cycles_ignored
  end

  assign db_d = s2_q;
`endif

  // Pulses are computed from the next debounced value so they line up with the
  // edge where db rises rather than one cycle later.
  assign press_d    = db_d[IdxStart:IdxJump] & ~db_q[IdxStart:IdxJump];
  // Set has priority over acknowledge on the same edge.
  assign jump_req_d = press_d[0] | (jump_req_q & ~jump_ack);
  assign move_dir_d = {db_q[IdxLeft] & ~db_q[IdxRight],
                       db_q[IdxRight] & ~db_q[IdxLeft]};

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      db_q       <= '0;
      press_q    <= '0;
      jump_req_q <= 1'b0;
      move_dir_q <= '0;
    end else begin
      s1_q       <= pin_act;
      s2_q       <= s1_q;
      db_q       <= db_d;
      press_q    <= press_d;
      jump_req_q <= jump_req_d;
      move_dir_q <= move_dir_d;
    end
  end

  assign move_dir    = move_dir_q;
  assign jump_level  = db_q[IdxJump];
  assign jump_press  = press_q[0];
  assign start_press = press_q[1];
  assign jump_req    = jump_req_q;

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed self-checking bench for input_conditioner

module tb_input_conditioner;

  localparam int D = 4;
`ifdef INPUT_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
  localparam int LAT = 1 + D;
`else
  localparam bit DEB = 1'b0;
  localparam int LAT = 2;
`endif

  logic       vga_clock = 1'b0;
  logic       reset;
  logic       left_switch;
  logic       right_switch;
  logic       jump_button;
  logic       start_button;
  logic       jump_ack;
  logic [1:0] move_dir;
  logic       jump_level;
  logic       jump_press;
  logic       jump_req;
  logic       start_press;

  int n_cmp = 0;
  int n_err = 0;

  always #5 vga_clock = ~vga_clock;

  input_conditioner #(
    .DEBOUNCE_CYCLES  (D),
    .BUTTON_ACTIVE_LOW(1'b1)
  ) dut (
    .vga_clock   (vga_clock),
    .reset       (reset),
    .left_switch (left_switch),
    .right_switch(right_switch),
    .jump_button (jump_button),
    .start_button(start_button),
    .jump_ack    (jump_ack),
    .move_dir    (move_dir),
    .jump_level  (jump_level),
    .jump_press  (jump_press),
    .jump_req    (jump_req),
    .start_press (start_press)
  );

  // Advance one clock; afterwards we sit 1 time unit past the rising edge.
  task automatic tick();
    @(posedge vga_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with every pin at its released level.
    reset        = 1'b1;
    left_switch  = 1'b0;
    right_switch = 1'b0;
    jump_button  = 1'b1;
    start_button = 1'b1;
    jump_ack     = 1'b0;
    tick(); tick(); tick();
    chk("rst_move_dir",    4'(move_dir),    4'd0);
    chk("rst_jump_level",  4'(jump_level),  4'd0);
    chk("rst_jump_press",  4'(jump_press),  4'd0);
    chk("rst_jump_req",    4'(jump_req),    4'd0);
    chk("rst_start_press", 4'(start_press), 4'd0);
    reset = 1'b0;
    tick(); tick();

    // Jump pressed and held: pulse exactly at edge LAT, level and request from LAT.
    jump_button = 1'b0;
    for (int e = 0; e <= LAT + 1; e++) begin
      tick();
      chk($sformatf("press_jp_e%0d", e),  4'(jump_press), 4'(e == LAT));
      chk($sformatf("press_lvl_e%0d", e), 4'(jump_level), 4'(e >= LAT));
      chk($sformatf("press_req_e%0d", e), 4'(jump_req),   4'(e >= LAT));
    end

    // Acknowledge clears the request on the edge that samples it.
    jump_ack = 1'b1;
    tick();
    jump_ack = 1'b0;
    chk("ack_clears_req", 4'(jump_req), 4'd0);

    // Release: no pulse on the falling debounced edge.
    jump_button = 1'b1;
    for (int e = 0; e <= LAT + 1; e++) begin
      tick();
      chk($sformatf("release_jp_e%0d", e), 4'(jump_press), 4'd0);
    end
    chk("release_level", 4'(jump_level), 4'd0);

    // New press whose pulse edge coincides with an acknowledge: set wins.
    jump_button = 1'b0;
    for (int e = 0; e < LAT; e++) tick();
    jump_ack = 1'b1;
    tick();
    jump_ack = 1'b0;
    chk("coinc_press", 4'(jump_press), 4'd1);
    chk("coinc_req",   4'(jump_req),   4'd1);
    tick();
    chk("coinc_req_hold", 4'(jump_req), 4'd1);
    jump_ack = 1'b1;
    tick();
    jump_ack = 1'b0;
    chk("coinc_req_clear", 4'(jump_req), 4'd0);
    jump_ack = 1'b1;
    tick();
    jump_ack = 1'b0;
    chk("ack_idle_no_effect", 4'(jump_req), 4'd0);
    jump_button = 1'b1;
    for (int e = 0; e < LAT + 3; e++) tick();

    // Start held low for 3 cycles only: filtered when debouncing, passed otherwise.
    start_button = 1'b0;
    for (int e = 0; e <= 8; e++) begin
      tick();
      if (e == 2) start_button = 1'b1;
      chk($sformatf("sglitch_sp_e%0d", e), 4'(start_press), 4'(!DEB && e == 2));
    end
    for (int e = 0; e < LAT + 3; e++) tick();

    // Full start press right after: a restarted count gives the full latency.
    start_button = 1'b0;
    for (int e = 0; e <= LAT + 1; e++) begin
      tick();
      chk($sformatf("start_sp_e%0d", e), 4'(start_press), 4'(e == LAT));
    end
    start_button = 1'b1;
    for (int e = 0; e < LAT + 3; e++) tick();

    // Direction switches: move_dir lags the debounced level by one edge.
    left_switch = 1'b1;
    for (int e = 0; e <= LAT + 1; e++) begin
      tick();
      chk($sformatf("left_md_e%0d", e), 4'(move_dir), (e >= LAT + 1) ? 4'd2 : 4'd0);
    end
    right_switch = 1'b1;
    for (int e = 0; e <= LAT + 1; e++) begin
      tick();
      chk($sformatf("both_md_e%0d", e), 4'(move_dir), (e >= LAT + 1) ? 4'd0 : 4'd2);
    end
    left_switch = 1'b0;
    for (int e = 0; e <= LAT + 1; e++) begin
      tick();
      chk($sformatf("right_md_e%0d", e), 4'(move_dir), (e >= LAT + 1) ? 4'd1 : 4'd0);
    end
    right_switch = 1'b0;
    for (int e = 0; e < LAT + 3; e++) tick();
    chk("idle_md", 4'(move_dir), 4'd0);

    // Button held, reset asserted mid-count, held through reset.
    jump_button = 1'b0;
    for (int e = 0; e <= 3; e++) tick();
    reset = 1'b1;
    tick();
    chk("midrst_level", 4'(jump_level), 4'd0);
    chk("midrst_press", 4'(jump_press), 4'd0);
    chk("midrst_req",   4'(jump_req),   4'd0);
    tick();
    chk("midrst_level2", 4'(jump_level), 4'd0);
    reset = 1'b0;
    for (int e = 0; e <= LAT + 1; e++) begin
      tick();
      chk($sformatf("postrst_jp_e%0d", e), 4'(jump_press), 4'(e == LAT));
    end
    jump_ack = 1'b1;
    tick();
    jump_ack = 1'b0;
    jump_button = 1'b1;
    for (int e = 0; e < LAT + 3; e++) tick();
    chk("postrst_req_clear", 4'(jump_req), 4'd0);

    // One-cycle low glitch on jump: pulse at edge 2 without counters, none with.
    jump_button = 1'b0;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e == 0) jump_button = 1'b1;
      chk($sformatf("jglitch_jp_e%0d", e), 4'(jump_press), 4'(!DEB && e == 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Conditions the raw board inputs (left/right slide switches, jump and start push-buttons) before they reach the game logic. Each input is synchronised with two flops, debounced with a per-input stability counter, and turned into clean levels, single-cycle press pulses and a held jump request with an acknowledge handshake. It sits between the board pins and `FinalProjectGameLogic`, in the `vga_clock` domain.

## Interface
- `DEBOUNCE_CYCLES`, 250000, stable cycles required before a debounced level changes (10 ms at 25 MHz); legal range ≥ 1
- `BUTTON_ACTIVE_LOW`, 1, 1 means push-button pins read 0 when pressed; switches are always active-high

- `vga_clock`  in  1  pixel clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `left_switch`  in  1  raw pin, asynchronous
- `right_switch`  in  1  raw pin, asynchronous
- `jump_button`  in  1  raw pin, asynchronous, polarity per `BUTTON_ACTIVE_LOW`
- `start_button`  in  1  raw pin, asynchronous, polarity per `BUTTON_ACTIVE_LOW`
- `jump_ack`  in  1  game logic consumed the jump request
- `move_dir`  out  2  00 idle, 01 right, 10 left; both switches on gives 00
- `jump_level`  out  1  debounced jump, active-high
- `jump_press`  out  1  one-cycle pulse on debounced jump rising edge
- `jump_req`  out  1  sticky jump request, cleared by `jump_ack`
- `start_press`  out  1  one-cycle pulse on debounced start rising edge

## Operation
- Polarity is normalised before synchronisation. Buttons are inverted when `BUTTON_ACTIVE_LOW` = 1. All internal signals are active-high.
- Sync: two flops per input, `s1` ← pin, `s2` ← `s1`.
- Debounce per input uses counter `cnt` of width `$clog2(DEBOUNCE_CYCLES)`, minimum 1, and register `db`. At each edge:
  - if `s2` == `db`: `cnt` ← 0
  - else if `cnt` == `DEBOUNCE_CYCLES`-1: `db` ← `s2`, `cnt` ← 0
  - else: `cnt` ← `cnt`+1
- A glitch shorter than `DEBOUNCE_CYCLES` cycles at `s2` resets `cnt` and never reaches `db`.
- `jump_press` and `start_press` are registered pulses. Each is high for the one cycle that starts at the edge where its `db` goes 0→1. No pulse on 1→0.
- `jump_req`:
  - set at the edge that raises `jump_press`
  - cleared at the edge where `jump_ack`=1 is sampled
  - if set and clear happen on the same edge, set wins and `jump_req` stays 1
  - `jump_ack` while `jump_req`=0 has no effect
- `move_dir` is registered from the debounced left and right levels: {`db_left` & ~`db_right`, `db_right` & ~`db_left`}.
- `jump_level` = `db_jump`.

## Timing
- Reset values:
  - all `s1`/`s2` registers hold the released level (0 after normalisation)
  - all `db`, all `cnt` = 0
  - `move_dir` = 00, `jump_level` = `jump_press` = `jump_req` = `start_press` = 0
- Reset mid-debounce discards the count. A button still held after reset is treated as a fresh press: its pulse comes a full latency after reset deasserts.
- Latency, with edge 0 being the first edge that samples a new stable pin value:
  - `s2` updates at edge 1
  - `db`, `jump_level` and the press pulse update at edge 1+`DEBOUNCE_CYCLES`
  - `move_dir` updates one edge after that
- `jump_req` rises on the same edge as `jump_press`. It falls on the edge that samples `jump_ack`, one cycle after the ack is driven.
- Back-to-back presses each need a release and a re-press, each debounced, so the minimum press spacing is 2·`DEBOUNCE_CYCLES` cycles.

## Configuration
- `INPUT_DEBOUNCE_EN` defined: counters present, behaviour as above.
- `INPUT_DEBOUNCE_EN` undefined:
  - counters removed and `db` ← `s2` every edge
  - latency from edge 0 to `db` and the pulses is 2 edges
  - `DEBOUNCE_CYCLES` is ignored
  - `jump_req` handshake, `move_dir` and polarity are unchanged

## Test plan
- Run all scenarios with `DEBOUNCE_CYCLES`=4 and `BUTTON_ACTIVE_LOW`=1, with `INPUT_DEBOUNCE_EN` defined unless stated.
- Reset, then `jump_button` driven 0 and held from edge 0 → `jump_press`=1 only in the cycle after edge 5; `jump_req`=1 from edge 5; `jump_level`=1 from edge 5.
- `start_button` low for 3 cycles, then high → no `start_press`, and `cnt` returns to 0.
- `jump_req`=1, `jump_ack` pulsed at cycle 10 → `jump_req`=0 after edge 10. Then a new debounced press with its edge coinciding with `jump_ack`=1 → `jump_req` stays 1.
- `left_switch`=1 → `move_dir`=10 at edge 6. Then `right_switch`=1 → 00. Then `left_switch`=0 → 01.
- Button held, `reset` asserted mid-count at `cnt`=2, then released → `db`=0 during reset; press pulse exactly 5 edges after the first post-reset sampling edge.
- `INPUT_DEBOUNCE_EN` undefined, 1-cycle low glitch on `jump_button` → `jump_press` fires 2 edges later.
